// File: rtl/pipe_add_arbiter.sv
// Round-robin arbiter sharing one external pipelined 4-bit adder among NREQ requesters.
// Optional per-requester grant counters are enabled with `define PIPE_ADD_ARB_STATS_EN.
module pipe_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_cin,
  input  logic [3:0]        add_sum,
  input  logic              add_cout,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [3:0]        resp_sum,
  output logic              resp_cout,
  output logic              busy
`ifdef PIPE_ADD_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0] grant_cnt
`endif
);

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;
  logic [LAT-1:0] vld_reg;
  logic [IDW-1:0] id_reg [LAT];

  // Search ptr, ptr+1, ... wrapping at NREQ; the first active request wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (en && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_reg) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_any && req[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        add_a   = req_a[4*i +: 4];
        add_b   = req_b[4*i +: 4];
        add_cin = req_cin[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr_reg <= '0;
    else if (gnt_any) begin
      if (int'(gnt_id) == NREQ - 1)
        ptr_reg <= '0;
      else
        ptr_reg <= gnt_id + 1'b1;
    end
  end

  // Tag pipe mirrors the adder latency so each result carries its owner.
  genvar gi;
  for (gi = 0; gi < LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_reg[gi] <= 1'b0;
          id_reg[gi]  <= '0;
        end else begin
          vld_reg[gi] <= gnt_any;
          id_reg[gi]  <= gnt_id;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_reg[gi] <= 1'b0;
          id_reg[gi]  <= '0;
        end else begin
          vld_reg[gi] <= vld_reg[gi-1];
          id_reg[gi]  <= id_reg[gi-1];
        end
      end
    end
  end

  assign resp_valid = vld_reg[LAT-1];
  assign resp_id    = id_reg[LAT-1];
  assign resp_sum   = add_sum;
  assign resp_cout  = add_cout;
  assign busy       = |vld_reg;

`ifdef PIPE_ADD_ARB_STATS_EN
  for (gi = 0; gi < NREQ; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg <= '0;
      else if (gnt[gi])
        cnt_reg <= cnt_reg + 16'd1;
    end
    assign grant_cnt[16*gi +: 16] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_pipe_add_arbiter.sv
// Randomized self-checking bench for pipe_add_arbiter with a cycle-indexed response schedule
// and a behavioural adder model; grant counters are checked when PIPE_ADD_ARB_STATS_EN is set.
module tb_pipe_add_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en;
  logic [NREQ-1:0]   req, req_cin, gnt;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [3:0]        add_a, add_b, add_sum, resp_sum;
  logic              add_cin, add_cout, resp_valid, resp_cout, busy;
  logic [IDW-1:0]    resp_id;
`ifdef PIPE_ADD_ARB_STATS_EN
  logic [16*NREQ-1:0] grant_cnt;
  int unsigned        m_cnt [NREQ];
`endif

  pipe_add_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy)
`ifdef PIPE_ADD_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  // External adder: LAT-edge pipelined 4-bit add with carry.
  logic [4:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign add_sum  = apipe[LAT-1][3:0];
  assign add_cout = apipe[LAT-1][4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mptr   = 0;
  bit         exp_v   [MAXC];
  int         exp_id  [MAXC];
  logic [4:0] exp_res [MAXC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, expv);
    end
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input bit r, input bit e, input logic [NREQ-1:0] rq,
                      input logic [4*NREQ-1:0] a, input logic [4*NREQ-1:0] b,
                      input logic [NREQ-1:0] ci);
    int g;
    int i;
    logic [3:0] ea, eb;
    logic       ec;
    bit         busy_e;
    rst = r; en = e; req = rq; req_a = a; req_b = b; req_cin = ci;
    #2;
    g = -1; ea = '0; eb = '0; ec = 1'b0;
    if (e && !r) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (mptr + k) % NREQ;
        if (g < 0 && rq[i]) g = i;
      end
    end
    if (g >= 0) begin
      ea = a[4*g +: 4];
      eb = b[4*g +: 4];
      ec = ci[g];
    end
    check("gnt", 64'(gnt), (g < 0) ? 64'd0 : (64'd1 << g));
    check("add_a", 64'(add_a), 64'(ea));
    check("add_b", 64'(add_b), 64'(eb));
    check("add_cin", 64'(add_cin), 64'(ec));
    check("resp_valid", 64'(resp_valid), 64'(exp_v[cyc]));
    if (exp_v[cyc]) begin
      check("resp_id", 64'(resp_id), 64'(exp_id[cyc]));
      check("resp_sum", 64'(resp_sum), 64'(exp_res[cyc][3:0]));
      check("resp_cout", 64'(resp_cout), 64'(exp_res[cyc][4]));
    end
    busy_e = 1'b0;
    for (int k = 0; k < LAT; k++) busy_e = busy_e | exp_v[cyc + k];
    check("busy", 64'(busy), 64'(busy_e));
`ifdef PIPE_ADD_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++) check("grant_cnt", 64'(grant_cnt[16*k +: 16]), 64'(m_cnt[k]));
`endif
    $display("cyc %0d rst %b en %b req %b gnt %b add %h+%h+%b resp_v %b id %0d sum %h cout %b busy %b",
             cyc, r, e, rq, gnt, add_a, add_b, add_cin, resp_valid, resp_id, resp_sum, resp_cout, busy);
    if (g >= 0) begin
      exp_v[cyc + LAT]   = 1'b1;
      exp_id[cyc + LAT]  = g;
      exp_res[cyc + LAT] = {1'b0, ea} + {1'b0, eb} + {4'b0, ec};
      mptr = (g + 1) % NREQ;
`ifdef PIPE_ADD_ARB_STATS_EN
      m_cnt[g] = (m_cnt[g] + 1) & 32'hFFFF;
`endif
    end
    if (r) begin
      mptr = 0;
      for (int k = 1; k <= LAT; k++) exp_v[cyc + k] = 1'b0;
`ifdef PIPE_ADD_ARB_STATS_EN
      for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; req_a = '0; req_b = '0; req_cin = '0;
`ifdef PIPE_ADD_ARB_STATS_EN
    for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    // Reset held: outputs quiet.
    step(1, 1, 4'b1111, 16'hFFFF, 16'hFFFF, 4'hF);
    // Single op from requester 2: 9 + 8 + 1 = 0x12.
    step(0, 1, 4'b0100, 16'h0900, 16'h0800, 4'b0100);
    repeat (5) step(0, 1, 4'b0000, 16'h0, 16'h0, 4'h0);
    // All requesting continuously.
    repeat (12) step(0, 1, 4'b1111, 16'($urandom), 16'($urandom), 4'($urandom));
    // Wrap-around fairness between 3 and 0.
    repeat (4) step(0, 1, 4'b1001, 16'($urandom), 16'($urandom), 4'($urandom));
    // Enable low: drain, pointer held.
    repeat (6) step(0, 0, 4'b1111, 16'($urandom), 16'($urandom), 4'($urandom));
    repeat (3) step(0, 1, 4'b1111, 16'($urandom), 16'($urandom), 4'($urandom));
    // Reset mid-flight.
    step(0, 1, 4'b0010, 16'h00F0, 16'h00F0, 4'b0010);
    step(0, 1, 4'b0100, 16'h0F00, 16'h0100, 4'b0000);
    step(1, 1, 4'b1000, 16'h7000, 16'h3000, 4'b1000);
    repeat (6) step(0, 1, 4'b1111, 16'($urandom), 16'($urandom), 4'($urandom));
    // Ten back-to-back ops from requester 1 only.
    step(1, 0, 4'b0000, 16'h0, 16'h0, 4'h0);
    repeat (10) step(0, 1, 4'b0010, 16'($urandom), 16'($urandom), 4'($urandom));
    repeat (5) step(0, 1, 4'b0000, 16'h0, 16'h0, 4'h0);
    // Randomized traffic with occasional enable drops and resets.
    repeat (400) step($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                      4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
    repeat (LAT + 1) step(0, 1, 4'b0000, 16'h0, 16'h0, 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
